// File: rtl/fifo_rd_packer_pkg.sv
// fifo_rd_packer_pkg: shared types, default parameters and helpers for the
// read-side FIFO packer.
//   word_t / keep_t : packed output word and lane-keep mask at default sizes
//   fill_keep()     : low-aligned keep mask for a given lane fill count
package fifo_rd_packer_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_PACK_RATIO = 4;
    localparam int unsigned DEF_TIMEOUT    = 16;
    localparam int unsigned DEF_WORD_W     = DEF_DATA_WIDTH * DEF_PACK_RATIO;

    // Widest pack ratio fill_keep() can describe; callers slice to their width.
    localparam int unsigned MAX_PACK_RATIO = 32;

    typedef logic [DEF_WORD_W-1:0]     word_t;
    typedef logic [DEF_PACK_RATIO-1:0] keep_t;

    // Ones in lanes [fill-1:0], zero above.
    function automatic logic [MAX_PACK_RATIO-1:0] fill_keep(input int unsigned fill);
        logic [MAX_PACK_RATIO-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MAX_PACK_RATIO; i++) begin
            if (i < fill) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/fifo_rd_idle_timer.sv
// fifo_rd_idle_timer: counts idle cycles and signals when TIMEOUT is reached.
//   clk      : clock
//   rst_n    : synchronous active-low reset
//   clr      : clear the count (wins over en)
//   en       : count this cycle
//   expire_c : combinational; high in the enabled cycle that reaches TIMEOUT,
//              and stays high while enabled until cleared
module fifo_rd_idle_timer
    import fifo_rd_packer_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;

    // The count saturates at TIMEOUT-1 so an expiry that cannot be acted on
    // (output register busy) stays pending rather than wrapping.
    assign expire_c = en && (count_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count_q <= '0;
        end else if (en && (count_q != LAST)) begin
            count_q <= count_q + CW'(1);
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: read-domain consumer of the async FIFO. Pops DATA_WIDTH
// entries and packs PACK_RATIO of them (first pop in lane 0) into one word
// presented on a valid/ready stream.
//   rd_clk, rd_rst_n : clock, synchronous active-low reset
//   rd_en            : FIFO pop request (combinational, never while empty)
//   rd_data, empty   : FIFO read data (cycle after pop), empty flag
//   out_valid/ready  : output handshake
//   out_data         : packed word
//   out_keep         : per-lane valid mask
// Build option: define FIFO_RD_PACKER_TIMEOUT_EN to flush a partial word after
// TIMEOUT idle cycles with a partial keep mask; otherwise keep is all ones.
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned PACK_RATIO = DEF_PACK_RATIO,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                             rd_clk,
    input  logic                             rd_rst_n,
    output logic                             rd_en,
    input  logic [DATA_WIDTH-1:0]            rd_data,
    input  logic                             empty,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
    output logic [PACK_RATIO-1:0]            out_keep
);

    localparam int unsigned WORD_W = DATA_WIDTH * PACK_RATIO;
    localparam int unsigned CNT_W  = $clog2(PACK_RATIO + 1);

    logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] asm_q;
    logic [CNT_W-1:0]                      cnt_q;
    logic                                  pend_q;

    logic [CNT_W-1:0] cnt_eff_c;
    logic             full_c;
    logic             slot_free_c;
    logic             xfer_c;
    logic             capture_c;
    logic             flush_c;

    // Output register can take a new word this cycle.
    assign slot_free_c = !out_valid || out_ready;
    assign full_c      = (cnt_q == CNT_W'(PACK_RATIO));
    assign xfer_c      = full_c && slot_free_c;
    assign cnt_eff_c   = xfer_c ? '0 : cnt_q;
    assign capture_c   = pend_q;

    // Pop only if the lane it will land in is guaranteed free, counting the
    // pop already in flight.
    assign rd_en = rd_rst_n && !empty && !flush_c &&
                   (({1'b0, cnt_eff_c} + {{CNT_W{1'b0}}, pend_q}) <
                    (CNT_W + 1)'(PACK_RATIO));

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    logic                                  idle_c;
    logic                                  expire_c;
    logic [PACK_RATIO-1:0]                 flush_keep_c;
    logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] flush_data_c;

    // Partial word parked with nothing arriving.
    assign idle_c = (cnt_q != '0) && !full_c && !pend_q && empty;

    fifo_rd_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk      (rd_clk),
        .rst_n    (rd_rst_n),
        .clr      (capture_c || flush_c),
        .en       (idle_c),
        .expire_c (expire_c)
    );

    assign flush_c = expire_c && slot_free_c;

    // Partial word with unfilled lanes forced to zero.
    always_comb begin
        flush_keep_c = PACK_RATIO'(fill_keep(32'(cnt_q)));
        for (int unsigned i = 0; i < PACK_RATIO; i++) begin
            flush_data_c[i] = flush_keep_c[i] ? asm_q[i] : '0;
        end
    end
`else
    logic unused_timeout;

    assign flush_c        = 1'b0;
    assign unused_timeout = ^32'(TIMEOUT);
`endif

    // Assembly lanes: data only, no reset needed.
    always_ff @(posedge rd_clk) begin
        for (int unsigned i = 0; i < PACK_RATIO; i++) begin
            if (rd_rst_n && capture_c && (cnt_eff_c == CNT_W'(i))) begin
                asm_q[i] <= rd_data;
            end
        end
    end

    // Fill count and in-flight tracking; a pre-reset pop is dropped with pend_q.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            pend_q <= rd_en;
            if (capture_c) begin
                cnt_q <= cnt_eff_c + CNT_W'(1);
            end else if (xfer_c || flush_c) begin
                cnt_q <= '0;
            end
        end
    end

    // Output register: loads on xfer/flush, otherwise clears on accept.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
        end else if (xfer_c) begin
            out_valid <= 1'b1;
            out_data  <= WORD_W'(asm_q);
            out_keep  <= '1;
        end
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
        else if (flush_c) begin
            out_valid <= 1'b1;
            out_data  <= WORD_W'(flush_data_c);
            out_keep  <= flush_keep_c;
        end
`endif
        else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: self-checking bench for fifo_rd_packer. A queue models
// the FIFO; a second queue holds every pushed entry in order and each
// accepted word is rebuilt from it.
module tb_fifo_rd_packer;
    import fifo_rd_packer_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned PR = 4;

    logic        rd_clk = 1'b0;
    logic        rd_rst_n;
    logic        rd_en;
    logic [DW-1:0] rd_data;
    logic        empty;
    logic        out_valid;
    logic        out_ready;
    word_t       out_data;
    keep_t       out_keep;

    fifo_rd_packer #(
        .DATA_WIDTH (DW),
        .PACK_RATIO (PR),
        .TIMEOUT    (16)
    ) dut (
        .rd_clk    (rd_clk),
        .rd_rst_n  (rd_rst_n),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep)
    );

    always #5 rd_clk = ~rd_clk;

    typedef struct {
        logic [7:0]  e0, e1, e2, e3;
        logic [31:0] exp_word;
        int          exp_lat;
    } vec_t;

    int n_cmp, n_fail, cyc, pops, words;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic force_empty;

    logic        s_rd_en, s_valid, s_ready;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    int          s_cyc;
    logic        hold_prev;
    logic [31:0] hold_data;
    logic [3:0]  hold_keep;

    vec_t        vecs[4];
    logic        got;
    logic [31:0] d;
    logic [3:0]  k;
    int          vc, last_pop, p0, nw, pushed, w0;
    logic [31:0] bp_w[3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic upd_empty();
        empty = force_empty || (fifo_q.size() == 0);
    endtask

    task automatic push(input logic [7:0] v);
        fifo_q.push_back(v);
        exp_q.push_back(v);
        upd_empty();
    endtask

    // Rebuild the expected word from the pushed-entry stream.
    task automatic sb_check();
        int n;
        int avail;
        logic [3:0]  ek;
        logic [31:0] ed;
        n = 0;
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
        for (int i = 0; i < PR; i++) if (s_keep[i]) n++;
        if (n == 0) n = 1;
`else
        n = PR;
`endif
        ek = 4'((1 << n) - 1);
        avail = (exp_q.size() < n) ? exp_q.size() : n;
        chk("sb_entries_avail", 64'(avail), 64'(n));
        ed = '0;
        for (int i = 0; i < avail; i++) ed[i*8 +: 8] = exp_q.pop_front();
        chk("sb_keep", 64'(s_keep), 64'(ek));
        chk("sb_data", 64'(s_data), 64'(ed));
        words++;
    endtask

    // One clock: sample/check at the falling edge, model the FIFO pop after the rising edge.
    task automatic tick();
        @(negedge rd_clk);
        s_rd_en = rd_en;
        s_valid = out_valid;
        s_ready = out_ready;
        s_data  = out_data;
        s_keep  = out_keep;
        s_cyc   = cyc;
        if (empty) chk("rd_en_while_empty", 64'(rd_en), 64'(0));
        if (!rd_rst_n) chk("rd_en_in_reset", 64'(rd_en), 64'(0));
        if (hold_prev) begin
            chk("hold_valid", 64'(s_valid), 64'(1));
            chk("hold_data", 64'(s_data), 64'(hold_data));
            chk("hold_keep", 64'(s_keep), 64'(hold_keep));
        end
        hold_prev = rd_rst_n && s_valid && !s_ready;
        hold_data = s_data;
        hold_keep = s_keep;
        if (rd_rst_n && s_valid && s_ready) sb_check();
        @(posedge rd_clk);
        #1;
        cyc++;
        if (s_rd_en) begin
            pops++;
            chk("pop_has_data", 64'(fifo_q.size() > 0), 64'(1));
            if (fifo_q.size() > 0) rd_data = fifo_q.pop_front();
        end
        upd_empty();
    endtask

    task automatic wait_word(input int budget, output logic g, output logic [31:0] wd,
                             output logic [3:0] wk, output int wc, inout int lp);
        g = 1'b0; wd = '0; wk = '0; wc = -1;
        for (int i = 0; i < budget && !g; i++) begin
            tick();
            if (s_rd_en) lp = s_cyc;
            if (s_valid) begin
                g = 1'b1; wd = s_data; wk = s_keep; wc = s_cyc;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0; pops = 0; words = 0;
        rd_rst_n = 1'b0; out_ready = 1'b0; force_empty = 1'b0; rd_data = '0;
        hold_prev = 1'b0; hold_data = '0; hold_keep = '0;

        // Latency counted in edges from the last pop to the edge raising out_valid.
        vecs[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211, 2};
        vecs[1] = '{8'hA5, 8'h5A, 8'h00, 8'hFF, 32'hFF005AA5, 2};
        vecs[2] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201, 2};
        vecs[3] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hEFBEADDE, 2};

        // Reset with data present: no pops allowed.
        fifo_q.push_back(8'hEE);
        upd_empty();
        repeat (3) tick();
        fifo_q.delete();
        upd_empty();
        rd_rst_n = 1'b1;
        tick();
        chk("rst_valid", 64'(s_valid), 64'(0));
        chk("rst_keep", 64'(s_keep), 64'(0));
        chk("rst_data", 64'(s_data), 64'(0));

        // Steady single words.
        out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            p0 = pops; last_pop = -1;
            push(vecs[v].e0); push(vecs[v].e1); push(vecs[v].e2); push(vecs[v].e3);
            wait_word(30, got, d, k, vc, last_pop);
            chk("vec_seen", 64'(got), 64'(1));
            chk("vec_data", 64'(d), 64'(vecs[v].exp_word));
            chk("vec_keep", 64'(k), 64'(4'hF));
            chk("vec_latency", 64'(vc - 1 - last_pop), 64'(vecs[v].exp_lat));
            repeat (4) tick();
            chk("vec_pops", 64'(pops - p0), 64'(4));
        end

        // Back-pressure: one word held at the output, one in assembly.
        out_ready = 1'b0; p0 = pops;
        for (int i = 0; i < 12; i++) push(8'(8'h10 + i));
        repeat (40) tick();
        chk("bp_pops", 64'(pops - p0), 64'(8));
        chk("bp_rd_en_idle", 64'(s_rd_en), 64'(0));
        chk("bp_valid", 64'(s_valid), 64'(1));
        chk("bp_first_word", 64'(s_data), 64'(32'h13121110));
        out_ready = 1'b1; nw = 0;
        for (int i = 0; i < 40 && nw < 3; i++) begin
            tick();
            if (s_valid && s_ready) begin
                bp_w[nw] = s_data;
                nw++;
            end
        end
        chk("bp_word_count", 64'(nw), 64'(3));
        chk("bp_word0", 64'(bp_w[0]), 64'(32'h13121110));
        chk("bp_word1", 64'(bp_w[1]), 64'(32'h17161514));
        chk("bp_word2", 64'(bp_w[2]), 64'(32'h1B1A1918));
        repeat (4) tick();

        // Reset with two entries captured and a third pop in flight.
        p0 = pops;
        push(8'hB0); push(8'hB1); push(8'hB2); push(8'hB3);
        for (int i = 0; i < 20 && (pops - p0) < 3; i++) tick();
        chk("rst_mid_pops", 64'(pops - p0), 64'(3));
        rd_rst_n = 1'b0;
        exp_q.delete();
        hold_prev = 1'b0;
        repeat (2) tick();
        fifo_q.delete();
        upd_empty();
        rd_rst_n = 1'b1;
        tick();
        chk("rst_mid_valid", 64'(s_valid), 64'(0));
        chk("rst_mid_keep", 64'(s_keep), 64'(0));
        last_pop = -1;
        push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
        wait_word(30, got, d, k, vc, last_pop);
        chk("rst_mid_seen", 64'(got), 64'(1));
        chk("rst_mid_word", 64'(d), 64'(32'hA3A2A1A0));
        chk("rst_mid_wkeep", 64'(k), 64'(4'hF));
        repeat (4) tick();

        // Random empty toggling and back-pressure.
        pushed = 0; w0 = words;
        for (int c = 0; c < 1000; c++) begin
            if (c < 900 && $urandom_range(0, 1) == 1) begin
                push(8'($urandom));
                pushed++;
            end
            if ($urandom_range(0, 7) == 0) force_empty = !force_empty;
            out_ready = ($urandom_range(0, 3) != 0);
            upd_empty();
            tick();
        end
        while ((pushed % PR) != 0) begin
            push(8'($urandom));
            pushed++;
        end
        force_empty = 1'b0; out_ready = 1'b1;
        upd_empty();
        for (int i = 0; i < 600 && (exp_q.size() != 0 || fifo_q.size() != 0); i++) tick();
        repeat (3) tick();
        chk("rand_drained", 64'(exp_q.size()), 64'(0));
`ifndef FIFO_RD_PACKER_TIMEOUT_EN
        chk("rand_word_count", 64'(words - w0), 64'(pushed / PR));
`endif

        // Partial word with the FIFO going empty.
        out_ready = 1'b1; last_pop = -1;
        push(8'h5A); push(8'h6B);
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
        // Flush lands 16 edges after the capture edge, i.e. 17 after the last pop edge.
        wait_word(60, got, d, k, vc, last_pop);
        chk("to_seen", 64'(got), 64'(1));
        chk("to_data", 64'(d), 64'(32'h00006B5A));
        chk("to_keep", 64'(k), 64'(4'h3));
        chk("to_latency", 64'(vc - 1 - last_pop), 64'(17));
        push(8'h7C); push(8'h8D);
        wait_word(60, got, d, k, vc, last_pop);
        chk("to2_seen", 64'(got), 64'(1));
        chk("to2_data", 64'(d), 64'(32'h00008D7C));
        chk("to2_keep", 64'(k), 64'(4'h3));
`else
        wait_word(100, got, d, k, vc, last_pop);
        chk("no_timeout_valid", 64'(got), 64'(0));
        push(8'h7C); push(8'h8D);
        wait_word(30, got, d, k, vc, last_pop);
        chk("late_seen", 64'(got), 64'(1));
        chk("late_data", 64'(d), 64'(32'h8D7C6B5A));
        chk("late_keep", 64'(k), 64'(4'hF));
`endif
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
